toy_fetch_filter: RTL and testbench

Fetch-block splitter that sits directly downstream of the BPU reorder buffer. It accepts one in-order fetch block per handshake on the filter interface and emits it as a stream of single 32-bit instructions, each with its PC, toward decode. It tracks the sequential fetch PC itself, so words below the current PC offset in a block are dropped; this covers a block fetched after a redirect to a non-aligned target. It holds exactly one fetch block and applies back-pressure to the ROB while that block is being drained.

---
 rtl/toy_fetch_filter_if.sv | 26 ++
 rtl/toy_fetch_filter.sv | 66 ++++++
 tb/tb_toy_fetch_filter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_fetch_filter_if.sv
// Fetch-filter handshake bundle: ROB-side block channel, decode-side instruction channel and front-end flush.
// master drives blocks, inst_rdy and flush; slave is the filter itself.
interface toy_fetch_filter_if #(
  parameter int FETCH_DATA_WIDTH = 128,
  parameter int INST_WIDTH       = 32
);
  logic                        filter_vld;
  logic                        filter_rdy;
  logic [FETCH_DATA_WIDTH-1:0] filter_pld;
  logic                        inst_vld;
  logic                        inst_rdy;
  logic [INST_WIDTH-1:0]       inst_pld;
  logic [31:0]                 inst_pc;
  logic                        fe_ctrl_flush;
  logic [31:0]                 fe_ctrl_flush_pc;

  modport master (
    output filter_vld, filter_pld, inst_rdy, fe_ctrl_flush, fe_ctrl_flush_pc,
    input  filter_rdy, inst_vld, inst_pld, inst_pc
  );

  modport slave (
    input  filter_vld, filter_pld, inst_rdy, fe_ctrl_flush, fe_ctrl_flush_pc,
    output filter_rdy, inst_vld, inst_pld, inst_pc
  );
endinterface

// File: rtl/toy_fetch_filter.sv
// Fetch-block splitter: holds one block, emits words from the current PC offset one per cycle, first word the cycle after accept.
// filter_rdy is low while a block drains except on the last-word handshake; flush beats every other event.
module toy_fetch_filter #(
  parameter int          FETCH_DATA_WIDTH = 128,
  parameter int          INST_WIDTH       = 32,
  parameter logic [31:0] RESET_PC         = 32'h8000_0000
) (
  input logic               clk,
  input logic               rst_n,
  toy_fetch_filter_if.slave bus
);
  localparam int WORDS = FETCH_DATA_WIDTH / INST_WIDTH;
  localparam int OFS_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                        r_buf_vld;
  logic [FETCH_DATA_WIDTH-1:0] r_buf_data;
  logic [29:0]                 r_pc_w;

  logic [INST_WIDTH-1:0] w_words [WORDS];
  logic [OFS_W-1:0]      w_ofs;
  logic                  w_last;
  logic                  w_out_fire;
  logic                  w_in_fire;
  logic                  w_filter_rdy;
  logic                  w_unused_pc_lsb;

  // PC is kept as a word address; the byte bits of the redirect target are dropped.
  assign w_unused_pc_lsb = &{1'b0, bus.fe_ctrl_flush_pc[1:0]};

  for (genvar k = 0; k < WORDS; k++) begin : g_word
    assign w_words[k] = r_buf_data[k*INST_WIDTH +: INST_WIDTH];
  end

  assign w_ofs        = r_pc_w[OFS_W-1:0];
  assign w_last       = (w_ofs == OFS_W'(WORDS - 1));
  assign w_out_fire   = r_buf_vld & bus.inst_rdy;
  assign w_filter_rdy = ~bus.fe_ctrl_flush & (~r_buf_vld | (w_out_fire & w_last));
  assign w_in_fire    = bus.filter_vld & w_filter_rdy;

  assign bus.filter_rdy = w_filter_rdy;
  assign bus.inst_vld   = r_buf_vld;
  assign bus.inst_pld   = w_words[w_ofs];
  assign bus.inst_pc    = {r_pc_w, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_vld  <= 1'b0;
      r_buf_data <= '0;
      r_pc_w     <= RESET_PC[31:2];
    end else if (bus.fe_ctrl_flush) begin
      // A same-cycle output handshake is consumed downstream but must not move the PC.
      r_buf_vld <= 1'b0;
      r_pc_w    <= bus.fe_ctrl_flush_pc[31:2];
    end else begin
      if (w_in_fire) begin
        r_buf_data <= bus.filter_pld;
        r_buf_vld  <= 1'b1;
      end else if (w_out_fire && w_last) begin
        r_buf_vld <= 1'b0;
      end
      if (w_out_fire) begin
        r_pc_w <= r_pc_w + 30'd1;
      end
    end
  end
endmodule

// File: tb/tb_toy_fetch_filter.sv
// Randomized and directed bench for toy_fetch_filter against a queue-of-expected-instructions model.
module tb_toy_fetch_filter;
  localparam int          FDW = 128;
  localparam int          IW  = 32;
  localparam int          W   = FDW / IW;
  localparam logic [31:0] RPC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0]   pc;
    logic [IW-1:0] d;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  toy_fetch_filter_if #(.FETCH_DATA_WIDTH(FDW), .INST_WIDTH(IW)) bus ();

  toy_fetch_filter #(
    .FETCH_DATA_WIDTH(FDW),
    .INST_WIDTH      (IW),
    .RESET_PC        (RPC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the instructions still owed to decode, plus the PC of the next block to fetch.
  ent_t        q[$];
  logic [31:0] m_pc = RPC;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_rdy();
    return !bus.fe_ctrl_flush && (q.size() == 0 || (q.size() == 1 && bus.inst_rdy));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pc = RPC;
    end else begin
      logic of_, if_;
      int   o;
      of_ = (q.size() != 0) && bus.inst_rdy;
      if_ = bus.filter_vld && m_rdy();
      if (bus.fe_ctrl_flush) begin
        q.delete();
        m_pc = {bus.fe_ctrl_flush_pc[31:2], 2'b00};
      end else begin
        if (of_) void'(q.pop_front());
        if (if_) begin
          ent_t e;
          logic [31:0] base;
          o    = int'((m_pc >> 2) % W);
          base = m_pc & ~32'(W * 4 - 1);
          for (int k = o; k < W; k++) begin
            e.pc = base + 32'(4 * k);
            e.d  = bus.filter_pld[k*IW +: IW];
            q.push_back(e);
          end
          m_pc = base + 32'(W * 4);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("inst_vld", 64'(bus.inst_vld), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("inst_pc", 64'(bus.inst_pc), 64'(q[0].pc));
      chk("inst_pld", 64'(bus.inst_pld), 64'(q[0].d));
    end else begin
      chk("inst_pc_idle", 64'(bus.inst_pc), 64'(m_pc));
    end
    chk("filter_rdy", 64'(bus.filter_rdy), 64'(m_rdy()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    bus.fe_ctrl_flush    = 1'b1;
    bus.fe_ctrl_flush_pc = pc;
    step();
    bus.fe_ctrl_flush    = 1'b0;
  endtask

  function automatic logic [FDW-1:0] mk_blk(input logic [15:0] tag);
    logic [FDW-1:0] b;
    for (int k = 0; k < W; k++) b[k*IW +: IW] = {tag, 16'(k)};
    return b;
  endfunction

  initial begin
    logic [FDW-1:0] b0, b1;
    bus.filter_vld       = 1'b0;
    bus.filter_pld       = '0;
    bus.inst_rdy         = 1'b0;
    bus.fe_ctrl_flush    = 1'b0;
    bus.fe_ctrl_flush_pc = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_inst_vld", 64'(bus.inst_vld), 64'd0);
    chk("rst_inst_pc", 64'(bus.inst_pc), 64'h8000_0000);
    chk("rst_inst_pld", 64'(bus.inst_pld), 64'd0);
    chk("rst_filter_rdy", 64'(bus.filter_rdy), 64'd1);
    step();
    rst_n = 1'b1;

    // One block, full-rate drain.
    b0 = mk_blk(16'hD0D0);
    bus.inst_rdy   = 1'b1;
    bus.filter_vld = 1'b1;
    bus.filter_pld = b0;
    step();
    bus.filter_vld = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("blk_pld", 64'(bus.inst_pld), 64'({16'hD0D0, 16'(k)}));
      chk("blk_pc", 64'(bus.inst_pc), 64'(32'h8000_0000 + 32'(4 * k)));
      if (k == W - 1) chk("blk_rdy_last", 64'(bus.filter_rdy), 64'd1);
      step();
    end

    // Redirect to a non-aligned word, then back-to-back blocks.
    flush_to(32'h8000_000B);
    b0 = mk_blk(16'hAAAA);
    b1 = mk_blk(16'hBBBB);
    bus.filter_vld = 1'b1;
    bus.filter_pld = b0;
    step();
    bus.filter_pld = b1;
    @(negedge clk);
    chk("redir_a2", 64'({bus.inst_pc, bus.inst_pld}), {32'h8000_0008, 32'hAAAA_0002});
    step();
    @(negedge clk);
    chk("redir_a3", 64'({bus.inst_pc, bus.inst_pld}), {32'h8000_000C, 32'hAAAA_0003});
    step();
    bus.filter_vld = 1'b0;
    @(negedge clk);
    chk("redir_b0", 64'({bus.inst_pc, bus.inst_pld}), {32'h8000_0010, 32'hBBBB_0000});
    step();
    @(negedge clk);
    chk("redir_b1", 64'({bus.inst_pc, bus.inst_pld}), {32'h8000_0014, 32'hBBBB_0001});

    // Random traffic with stalls and occasional redirects, checked every cycle by the model.
    for (int c = 0; c < 600; c++) begin
      step();
      bus.inst_rdy   = ($urandom_range(0, 2) != 0);
      bus.filter_vld = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < W; k++) bus.filter_pld[k*IW +: IW] = $urandom;
      bus.fe_ctrl_flush = ($urandom_range(0, 19) == 0);
      bus.fe_ctrl_flush_pc = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
    end
    step();
    bus.fe_ctrl_flush = 1'b0;
    bus.filter_vld    = 1'b0;
    bus.inst_rdy      = 1'b1;

    // Flush during word 1 while the ROB offers a block.
    flush_to(32'h8000_0100);
    bus.filter_vld = 1'b1;
    bus.filter_pld = mk_blk(16'hC0C0);
    step();
    bus.filter_vld = 1'b0;
    step();
    bus.fe_ctrl_flush    = 1'b1;
    bus.fe_ctrl_flush_pc = 32'h8000_0200;
    bus.filter_vld       = 1'b1;
    bus.filter_pld       = mk_blk(16'hEEEE);
    @(negedge clk);
    chk("flush_w1_pc", 64'(bus.inst_pc), 64'h8000_0104);
    chk("flush_rdy", 64'(bus.filter_rdy), 64'd0);
    step();
    bus.fe_ctrl_flush = 1'b0;
    bus.filter_vld    = 1'b0;
    @(negedge clk);
    chk("flush_vld_drop", 64'(bus.inst_vld), 64'd0);
    chk("flush_idle_pc", 64'(bus.inst_pc), 64'h8000_0200);
    bus.filter_vld = 1'b1;
    step();
    bus.filter_vld = 1'b0;
    @(negedge clk);
    chk("flush_new", 64'({bus.inst_pc, bus.inst_pld}), {32'h8000_0200, 32'hEEEE_0000});
    step();
    step();
    step();

    // PC wrap at the top of the address space.
    flush_to(32'hFFFF_FFF8);
    bus.filter_vld = 1'b1;
    bus.filter_pld = mk_blk(16'hF00F);
    step();
    bus.filter_pld = mk_blk(16'h6060);
    @(negedge clk);
    chk("wrap_f2", 64'({bus.inst_pc, bus.inst_pld}), {32'hFFFF_FFF8, 32'hF00F_0002});
    step();
    @(negedge clk);
    chk("wrap_f3", 64'({bus.inst_pc, bus.inst_pld}), {32'hFFFF_FFFC, 32'hF00F_0003});
    step();
    bus.filter_vld = 1'b0;
    @(negedge clk);
    chk("wrap_g0", 64'({bus.inst_pc, bus.inst_pld}), {32'h0000_0000, 32'h6060_0000});
    for (int k = 0; k < W; k++) step();

    // Asynchronous reset with two words still owed.
    flush_to(32'h8000_0300);
    bus.filter_vld = 1'b1;
    bus.filter_pld = mk_blk(16'h7777);
    step();
    bus.filter_vld = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.inst_vld), 64'd0);
    chk("arst_pc", 64'(bus.inst_pc), 64'h8000_0000);
    chk("arst_rdy", 64'(bus.filter_rdy), 64'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    chk("arst_stays_idle", 64'(bus.inst_vld), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
